// File: rtl/mas_vedic_combine_pipe_8b.sv
// Combines four 4x4 Vedic partial products into a 16-bit 8x8 product.
// Two-stage valid/ready pipeline built on ripple-carry adders.

module mas_full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);
  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));
endmodule

module mas_ripple_carry_adder_4b (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);
  logic [4:0] carry;

  assign carry[0] = cin_i;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    mas_full_adder u_fa (
      .a_i    (a_i[i]),
      .b_i    (b_i[i]),
      .cin_i  (carry[i]),
      .sum_o  (sum_o[i]),
      .cout_o (carry[i+1])
    );
  end

  assign cout_o = carry[4];
endmodule

module mas_ripple_carry_adder_8b (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       cin_i,
  output logic [7:0] sum_o,
  output logic       cout_o
);
  logic [8:0] carry;

  assign carry[0] = cin_i;

  for (genvar i = 0; i < 8; i++) begin : g_bit
    mas_full_adder u_fa (
      .a_i    (a_i[i]),
      .b_i    (b_i[i]),
      .cin_i  (carry[i]),
      .sum_o  (sum_o[i]),
      .cout_o (carry[i+1])
    );
  end

  assign cout_o = carry[8];
endmodule

module mas_vedic_combine_pipe_8b #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       pp0,
  input  logic [7:0]       pp1,
  input  logic [7:0]       pp2,
  input  logic [7:0]       pp3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      product,
  output logic             busy,
  output logic [CNT_W-1:0] prod_cnt
);
  // Handshake: a transfer happens on a cycle where valid && ready are both
  // high at the rising edge; valid never waits on ready, in_ready is a pure
  // function of register state and out_ready, and held output data is stable.

  logic             s1_valid_q, s1_valid_d;
  logic             s2_valid_q, s2_valid_d;
  logic [7:0]       s1_sum_q;
  logic             s1_c_q;
  logic [7:0]       s1_pp0_q;
  logic [7:0]       s1_pp3_q;
  logic [15:0]      prod_q;
  logic [CNT_W-1:0] prod_cnt_q, prod_cnt_d;

  logic             s1_accept;
  logic             s2_load;
  logic             out_fire;
  logic [7:0]       s1_sum;
  logic             s1_c;
  logic [7:0]       mid_sum;
  logic             mid_c;
  logic [3:0]       hi_sum;
  logic             hi_cout;

  assign s2_load   = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready  = !s1_valid_q || s2_load;
  assign s1_accept = in_valid && in_ready;
  assign out_fire  = s2_valid_q && out_ready;

  mas_ripple_carry_adder_8b u_s1_add (
    .a_i    (pp1),
    .b_i    (pp2),
    .cin_i  (1'b0),
    .sum_o  (s1_sum),
    .cout_o (s1_c)
  );

  // Middle byte: the upper pp0 nibble and lower pp3 nibble line up with s1.
  mas_ripple_carry_adder_8b u_s2_mid (
    .a_i    ({s1_pp3_q[3:0], s1_pp0_q[7:4]}),
    .b_i    (s1_sum_q),
    .cin_i  (1'b0),
    .sum_o  (mid_sum),
    .cout_o (mid_c)
  );

  mas_ripple_carry_adder_4b u_s2_hi (
    .a_i    (s1_pp3_q[7:4]),
    .b_i    ({3'b000, s1_c_q}),
    .cin_i  (mid_c),
    .sum_o  (hi_sum),
    .cout_o (hi_cout)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (s1_accept) begin
      s1_valid_d = 1'b1;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    s2_valid_d = s2_valid_q;
    if (s2_load) begin
      s2_valid_d = 1'b1;
    end else if (out_fire) begin
      s2_valid_d = 1'b0;
    end

    prod_cnt_d = prod_cnt_q;
    if (out_fire && (prod_cnt_q != {CNT_W{1'b1}})) begin
      prod_cnt_d = prod_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      prod_cnt_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      prod_cnt_q <= prod_cnt_d;
    end
  end

  // Data registers carry no reset; their contents only matter behind a valid.
  always_ff @(posedge clk) begin
    if (s1_accept) begin
      s1_sum_q <= s1_sum;
      s1_c_q   <= s1_c;
      s1_pp0_q <= pp0;
      s1_pp3_q <= pp3;
    end
    if (s2_load) begin
      prod_q <= {hi_sum, mid_sum, s1_pp0_q[3:0]};
    end
  end

  // Genuine partial products can never carry out of the top nibble.
  a_hi_no_carry : assert property (@(posedge clk) disable iff (!rst_n)
    s1_valid_q |-> !hi_cout);

  assign out_valid = s2_valid_q;
  assign product   = prod_q;
  assign busy      = s1_valid_q || s2_valid_q;
  assign prod_cnt  = prod_cnt_q;

endmodule

// File: tb/tb_mas_vedic_combine_pipe_8b.sv
// Bench for mas_vedic_combine_pipe_8b: vector table, directed handshake
// sequences and random traffic against a transaction-level product model.

module tb_mas_vedic_combine_pipe_8b;
  localparam int CLK_P = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #(CLK_P/2) clk = ~clk;
  logic rst_n;

  // main instance (CNT_W = 16)
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [7:0]  pp0, pp1, pp2, pp3;
  logic [15:0] product;
  logic [15:0] prod_cnt;

  // saturation instance (CNT_W = 3)
  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_busy;
  logic [7:0]  s_pp0, s_pp1, s_pp2, s_pp3;
  logic [15:0] s_product;
  logic [2:0]  s_prod_cnt;

  mas_vedic_combine_pipe_8b #(.CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pp0       (pp0),
    .pp1       (pp1),
    .pp2       (pp2),
    .pp3       (pp3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy),
    .prod_cnt  (prod_cnt)
  );

  mas_vedic_combine_pipe_8b #(.CNT_W(3)) dut_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .pp0       (s_pp0),
    .pp1       (s_pp1),
    .pp2       (s_pp2),
    .pp3       (s_pp3),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .product   (s_product),
    .busy      (s_busy),
    .prod_cnt  (s_prod_cnt)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
  } vec_t;
  vec_t tbl[10];

  logic [15:0] cur_prod, s_cur_prod;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // {pp3, pp2, pp1, pp0} from the two 8-bit operands
  function automatic logic [31:0] make_pp(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] al, ah, bl, bh;
    logic [7:0] p0, p1, p2, p3;
    al = {4'h0, a[3:0]};
    ah = {4'h0, a[7:4]};
    bl = {4'h0, b[3:0]};
    bh = {4'h0, b[7:4]};
    p0 = al * bl;
    p1 = ah * bl;
    p2 = al * bh;
    p3 = ah * bh;
    return {p3, p2, p1, p0};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_main(input logic v, input logic [7:0] a, input logic [7:0] b);
    in_valid = v;
    {pp3, pp2, pp1, pp0} = make_pp(a, b);
    cur_prod = 16'(a) * 16'(b);
  endtask

  task automatic drive_sat(input logic v, input logic [7:0] a, input logic [7:0] b);
    s_in_valid = v;
    {s_pp3, s_pp2, s_pp1, s_pp0} = make_pp(a, b);
    s_cur_prod = 16'(a) * 16'(b);
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, output int waits);
    bit ok;
    ok = 1'b0;
    waits = 0;
    drive_main(1'b1, a, b);
    while (!ok && waits < 50) begin
      ok = in_ready;
      waits++;
      tick();
    end
    in_valid = 1'b0;
    check("send_accepted", 32'(ok), 32'd1);
  endtask

  task automatic drain(input string name, output int n);
    n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (busy !== 1'b0 && n < 50) begin
      tick();
      n++;
    end
    check(name, 32'(n < 50), 32'd1);
  endtask

  task automatic single_shot(input int idx, input int exp_cnt);
    int w;
    out_ready = 1'b1;
    send(tbl[idx].a, tbl[idx].b, w);
    @(negedge clk);
    check("ss_out_valid_c1", 32'(out_valid), 32'd0);
    tick();
    @(negedge clk);
    check("ss_out_valid_c2", 32'(out_valid), 32'd1);
    check("ss_product", 32'(product), 32'(tbl[idx].prod));
    tick();
    check("ss_prod_cnt", 32'(prod_cnt), 32'(exp_cnt));
    check("ss_out_valid_c3", 32'(out_valid), 32'd0);
  endtask

  // ---------------- scoreboard / reference model ----------------
  // Each accepted set is queued with its age in cycles; the oldest becomes
  // visible two cycles after its accept cycle and leaves on a transfer.
  logic [15:0] exp_q[$];
  int          age_q[$];
  logic [15:0] got_q[$];
  int          got_cyc_q[$];
  logic [15:0] s_exp_q[$];
  int          model_cnt = 0;
  int          s_xfers   = 0;
  bit          armed     = 1'b0;
  logic        m_exp_ov, m_exp_ir;

  always @(negedge clk) begin
    cyc++;
    if (armed) begin
      for (int i = 0; i < age_q.size(); i++) age_q[i] = age_q[i] + 1;
      m_exp_ov = 1'b0;
      if (exp_q.size() > 0) m_exp_ov = (age_q[0] >= 2);
      m_exp_ir = (exp_q.size() < 2) || out_ready;

      check("busy", 32'(busy), 32'(exp_q.size() != 0));
      check("in_ready", 32'(in_ready), 32'(m_exp_ir));
      check("out_valid", 32'(out_valid), 32'(m_exp_ov));
      check("prod_cnt", 32'(prod_cnt), 32'(model_cnt));
      if (m_exp_ov) check("product", 32'(product), 32'(exp_q[0]));
      check("sat_prod_cnt", 32'(s_prod_cnt), 32'((s_xfers > 7) ? 7 : s_xfers));

      if (rst_n) begin
        if (m_exp_ov && out_ready) begin
          got_q.push_back(product);
          got_cyc_q.push_back(cyc);
          void'(exp_q.pop_front());
          void'(age_q.pop_front());
          if (model_cnt != 65535) model_cnt++;
        end
        if (in_valid && m_exp_ir) begin
          exp_q.push_back(cur_prod);
          age_q.push_back(0);
        end
        if (s_out_valid && s_out_ready) begin
          if (s_exp_q.size() == 0) begin
            check("sat_unexpected_out", 32'(s_out_valid), 32'd0);
          end else begin
            check("sat_product", 32'(s_product), 32'(s_exp_q[0]));
            void'(s_exp_q.pop_front());
          end
          s_xfers++;
        end
        if (s_in_valid && s_in_ready) s_exp_q.push_back(s_cur_prod);
      end
    end
    if (!rst_n) begin
      exp_q.delete();
      age_q.delete();
      s_exp_q.delete();
      model_cnt = 0;
      s_xfers   = 0;
      armed     = 1'b1;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #(CLK_P * 20000);
    $display("FAIL watchdog: simulation did not finish (checks %0d, errors %0d)", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------- test sequence ----------------
  initial begin
    int w, n, acc, base;
    logic [7:0] ra, rb;

    tbl[0] = '{8'h12, 8'h34, 16'h03A8};
    tbl[1] = '{8'hFF, 8'hFF, 16'hFE01};
    tbl[2] = '{8'h00, 8'h00, 16'h0000};
    tbl[3] = '{8'h01, 8'hFF, 16'h00FF};
    tbl[4] = '{8'hFF, 8'h01, 16'h00FF};
    tbl[5] = '{8'h80, 8'h80, 16'h4000};
    tbl[6] = '{8'h0F, 8'hF0, 16'h0E10};
    tbl[7] = '{8'hAA, 8'h55, 16'h3872};
    tbl[8] = '{8'h10, 8'h10, 16'h0100};
    tbl[9] = '{8'h7F, 8'h02, 16'h00FE};

    rst_n = 1'b0;
    drive_main(1'b0, 8'h00, 8'h00);
    drive_sat(1'b0, 8'h00, 8'h00);
    out_ready   = 1'b1;
    s_out_ready = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // reset state
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_prod_cnt", 32'(prod_cnt), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // single products: latency and carry paths
    single_shot(0, 1);
    single_shot(1, 2);

    // back-to-back streaming of the remaining table entries
    base = got_q.size();
    out_ready = 1'b1;
    for (int i = 2; i < 10; i++) begin
      send(tbl[i].a, tbl[i].b, w);
      check("stream_no_stall", 32'(w), 32'd1);
    end
    drain("stream_drain", n);
    check("stream_count", 32'(got_q.size() - base), 32'd8);
    if (got_q.size() - base == 8) begin
      for (int i = 0; i < 8; i++) begin
        check("stream_product", 32'(got_q[base+i]), 32'(tbl[i+2].prod));
        check("stream_consecutive", 32'(got_cyc_q[base+i] - got_cyc_q[base]), 32'(i));
      end
    end

    // backpressure: out_ready low for 5 cycles with in_valid held high
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      drive_main(1'b1, tbl[5+acc].a, tbl[5+acc].b);
      if (in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    check("bp_accepts", 32'(acc), 32'd2);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_product_held", 32'(product), 32'h4000);
    base = got_q.size();
    drain("bp_drain", n);
    check("bp_drain_cycles", 32'(n), 32'd2);
    check("bp_count", 32'(got_q.size() - base), 32'd2);
    if (got_q.size() - base == 2) begin
      check("bp_first", 32'(got_q[base]), 32'h4000);
      check("bp_second", 32'(got_q[base+1]), 32'h0E10);
    end

    // reset with both stages full
    out_ready = 1'b0;
    drive_main(1'b1, tbl[7].a, tbl[7].b);
    tick();
    drive_main(1'b1, tbl[8].a, tbl[8].b);
    tick();
    in_valid = 1'b0;
    check("mid_busy_before", 32'(busy), 32'd1);
    check("mid_out_valid_before", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_out_valid", 32'(out_valid), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_prod_cnt", 32'(prod_cnt), 32'd0);
    check("mid_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    repeat (3) tick();

    // CNT_W=3 instance: 9 transfers saturate at 7
    s_out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive_sat(1'b1, 8'($urandom), 8'($urandom));
      check("sat_in_ready", 32'(s_in_ready), 32'd1);
      tick();
    end
    s_in_valid = 1'b0;
    repeat (4) tick();
    check("sat_busy", 32'(s_busy), 32'd0);
    check("sat_cnt_final", 32'(s_prod_cnt), 32'd7);
    check("sat_transfers", 32'(s_xfers), 32'd9);
    repeat (3) tick();
    check("sat_cnt_hold", 32'(s_prod_cnt), 32'd7);

    // random traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      if ($urandom_range(0, 7) == 0) ra = 8'hFF;
      if ($urandom_range(0, 7) == 0) rb = 8'hFF;
      drive_main($urandom_range(0, 3) != 0, ra, rb);
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    drain("rand_drain", n);
    check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
